imem_loader: RTL and testbench

- Boot-time loader directly upstream of the single-cycle CPU's instruction memory.
- Receives a framed byte stream (UART/debug bridge, or bench driver in simulation) over valid/ready.
- Assembles 32-bit little-endian instruction words and writes them sequentially into imem from address 0.
- Holds the CPU in reset until the whole image is written; in simulation this replaces preloading imem from a file.

---
 rtl/imem_loader.sv | 231 +++++++++++++++++++++++
 tb/tb_imem_loader.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader -- boot-time instruction memory loader.
//
// Receives a framed byte stream over valid/ready:
//   CNT_LO, CNT_HI (16-bit word count N, little-endian), then 4*N data bytes.
// Each group of 4 bytes forms one little-endian 32-bit word (first byte is bits 7:0).
// Words are written sequentially into imem starting at word address 0.
// The CPU is held in reset (cpu_hold = 1) until the whole image has been written.
//
// Optional feature: define IMEM_LOADER_CSUM_EN to require a trailing checksum byte.
// That byte is the XOR of all 4*N data bytes and is still required when N = 0.
// A mismatching checksum ends in ERR. The words have already been written by then.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-low reset
//   start         re-arm pulse, honoured only in DONE or ERR
//   in_valid      byte-stream valid
//   in_data       byte-stream data
//   in_ready      loader can accept a byte this cycle (decoded from state only)
//   imem_we       imem write strobe, one cycle per word
//   imem_waddr    imem word address
//   imem_wdata    instruction word
//   cpu_hold      high keeps the CPU in reset
//   done          image loaded successfully
//   error         frame rejected or timed out
//   words_loaded  number of words written in this frame
module imem_loader #(
    parameter int IMEM_DEPTH     = 256,
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int WL_W  = ADDR_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    // Idle count at which the next idle cycle is the last one allowed.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_HI,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
`ifdef IMEM_LOADER_CSUM_EN
        , S_CSUM
`endif
    } state_t;

    // State entered once the last word is written (or immediately when N = 0).
`ifdef IMEM_LOADER_CSUM_EN
    localparam state_t S_AFTER_LAST = S_CSUM;
`else
    localparam state_t S_AFTER_LAST = S_DONE;
`endif

    state_t          state_q, state_d;
    logic [7:0]      cnt_lo_q, cnt_lo_d;
    logic [15:0]     n_q, n_d;
    logic [31:0]     asm_q, asm_d;
    logic [1:0]      idx_q, idx_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [WL_W-1:0] words_q, words_d;
    logic            hold_q, hold_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0]      csum_q, csum_d;
`endif

    logic            ready;
    logic            timed;
    logic [WL_W-1:0] words_inc;
    logic [15:0]     n_cand;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_lo_q <= '0;
            n_q      <= '0;
            asm_q    <= '0;
            idx_q    <= '0;
            tmo_q    <= '0;
            words_q  <= '0;
            hold_q   <= 1'b1;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_lo_q <= cnt_lo_d;
            n_q      <= n_d;
            asm_q    <= asm_d;
            idx_q    <= idx_d;
            tmo_q    <= tmo_d;
            words_q  <= words_d;
            hold_q   <= hold_d;
            done_q   <= done_d;
            error_q  <= error_d;
`ifdef IMEM_LOADER_CSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_lo_d  = cnt_lo_q;
        n_d       = n_q;
        asm_d     = asm_q;
        idx_d     = idx_q;
        tmo_d     = '0;
        words_d   = words_q;
`ifdef IMEM_LOADER_CSUM_EN
        csum_d    = csum_q;
`endif
        ready     = 1'b0;
        timed     = 1'b0;
        words_inc = words_q + WL_W'(1);
        n_cand    = {in_data, cnt_lo_q};

        case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                if (in_valid) begin
                    cnt_lo_d = in_data;
                    state_d  = S_CNT_HI;
`ifdef IMEM_LOADER_CSUM_EN
                    csum_d   = '0;
`endif
                end
            end
            S_CNT_HI: begin
                ready = 1'b1;
                timed = 1'b1;
                if (in_valid) begin
                    n_d     = n_cand;
                    words_d = '0;
                    idx_d   = '0;
                    if (n_cand == 16'd0) begin
                        state_d = S_AFTER_LAST;
                    end else if (n_cand > 16'(IMEM_DEPTH)) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                ready = 1'b1;
                timed = 1'b1;
                if (in_valid) begin
                    // Shift in from the top so the first byte ends up in bits 7:0.
                    asm_d = {in_data, asm_q[31:8]};
                    idx_d = idx_q + 2'd1;
`ifdef IMEM_LOADER_CSUM_EN
                    csum_d = csum_q ^ in_data;
`endif
                    if (idx_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                words_d = words_inc;
                state_d = (16'(words_inc) == n_q) ? S_AFTER_LAST : S_DATA;
            end
`ifdef IMEM_LOADER_CSUM_EN
            S_CSUM: begin
                ready = 1'b1;
                timed = 1'b1;
                if (in_valid) begin
                    state_d = (in_data == csum_q) ? S_DONE : S_ERR;
                end
            end
`endif
            S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_IDLE;
                    words_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Idle-cycle watchdog inside a frame; any accepted byte restarts it.
        if (timed && !in_valid) begin
            if (tmo_q == TMO_LAST) begin
                state_d = S_ERR;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
        if (state_d != state_q) begin
            tmo_d = '0;
        end

        // Status flags are registered so they change on the same edge as the state.
        done_d  = (state_d == S_DONE);
        error_d = (state_d == S_ERR);
        hold_d  = (state_d != S_DONE);
    end

    assign in_ready     = ready;
    assign imem_we      = (state_q == S_WRITE);
    assign imem_waddr   = words_q[ADDR_W-1:0];
    assign imem_wdata   = asm_q;
    assign cpu_hold     = hold_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader (default build, checksum feature disabled).
// A frame-level model derives the expected imem writes and the final status from the byte list.
// A compare process checks every imem write against the model on each cycle.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        imem_we;
    logic [7:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [8:0]  words_loaded;

    imem_loader #(
        .IMEM_DEPTH(256),
        .ADDR_W(8),
        .TIMEOUT_CYCLES(1024)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .imem_we(imem_we),
        .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold),
        .done(done),
        .error(error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    int          vectors = 0;
    int          miscompares = 0;
    int          we_count = 0;
    logic [31:0] mem [0:255];
    wr_t         exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, want);
        end
    endtask

    // Frame model: word count from the header, then whole little-endian words.
    // An incomplete or oversize frame must end in error.
    task automatic model_frame(input logic [7:0] b[$], output bit exp_err, output int exp_words);
        int n;
        n = int'(b[0]) | (int'(b[1]) << 8);
        exp_q.delete();
        exp_err = (n > 256) || (b.size() < 2 + 4 * n);
        if (n <= 256) begin
            for (int i = 0; i < n; i++) begin
                if (2 + 4 * i + 3 < b.size()) begin
                    exp_q.push_back(wr_t'{addr: i,
                        data: {b[2+4*i+3], b[2+4*i+2], b[2+4*i+1], b[2+4*i]}});
                end
            end
        end
        exp_words = exp_q.size();
    endtask

    // Compare process: every imem write must be the next one the model predicts.
    initial begin
        forever begin
            @(negedge clk);
            if (imem_we === 1'b1) begin
                we_count++;
                mem[imem_waddr] = imem_wdata;
                chk("ready_low_in_write", in_ready, 1'b0);
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_write: got addr %0d data %h, expected no write",
                             imem_waddr, imem_wdata);
                end else begin
                    chk("write_addr", imem_waddr, exp_q[0].addr);
                    chk("write_data", imem_wdata, exp_q[0].data);
                    void'(exp_q.pop_front());
                end
            end
            if (rst === 1'b1) begin
                chk("hold_vs_done", cpu_hold, !done);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at the negedge following acceptance.
    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("byte_accept_timeout", (t < 50), 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (done !== 1'b1 && error !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("result_timeout", (lat < 50), 1'b1);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] b[$], input int gap, output int lat);
        bit e;
        int nw;
        int wc0;
        model_frame(b, e, nw);
        wc0 = we_count;
        foreach (b[i]) begin
            send_byte(b[i]);
            repeat (gap) @(negedge clk);
        end
        wait_result(lat);
        chk({tag, "_done"}, done, !e);
        chk({tag, "_error"}, error, e);
        chk({tag, "_cpu_hold"}, cpu_hold, e);
        chk({tag, "_words_loaded"}, words_loaded, nw);
        chk({tag, "_in_ready"}, in_ready, 1'b0);
        chk({tag, "_pending_writes"}, exp_q.size(), 0);
        chk({tag, "_we_pulses"}, we_count - wc0, nw);
        $display("frame %s: %0d bytes, done=%0b error=%0b words=%0d", tag, b.size(), done, error, words_loaded);
    endtask

    task automatic pulse_start(input string tag);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_start_done"}, done, 1'b0);
        chk({tag, "_start_error"}, error, 1'b0);
        chk({tag, "_start_hold"}, cpu_hold, 1'b1);
        chk({tag, "_start_words"}, words_loaded, 0);
        chk({tag, "_start_ready"}, in_ready, 1'b1);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    endtask

    initial begin
        logic [7:0] f1[$];
        logic [7:0] f0[$];
        logic [7:0] fover[$];
        logic [7:0] fto[$];
        int  lat;
        bit  e;
        int  nw;
        int  wc0;

        f1    = '{8'h02, 8'h00, 8'h93, 8'h02, 8'h50, 8'h00, 8'hB3, 8'h82, 8'h32, 8'h00};
        f0    = '{8'h00, 8'h00};
        fover = '{8'h01, 8'h01};
        fto   = '{8'h02, 8'h00, 8'h93, 8'h02, 8'h50};
        clear_mem();

        // Reset values
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_imem_we", imem_we, 1'b0);
        chk("rst_waddr", imem_waddr, 0);
        chk("rst_wdata", imem_wdata, 0);
        chk("rst_cpu_hold", cpu_hold, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_words", words_loaded, 0);
        rst = 1'b1;
        @(negedge clk);

        // Two-word load
        run_frame("load2", f1, 0, lat);
        chk("load2_mem0", mem[0], 32'h00500293);
        chk("load2_mem1", mem[1], 32'h003282B3);
        chk("load2_words_lit", words_loaded, 2);
        pulse_start("load2");

        // N = 0: done must already be high at the first sample after CNT_HI
        run_frame("n0", f0, 0, lat);
        chk("n0_latency", lat, 0);
        pulse_start("n0");

        // Oversize count
        run_frame("over", fover, 0, lat);
        chk("over_error_lit", error, 1'b1);
        pulse_start("over");

        // Timeout after 3 data bytes, then restart
        model_frame(fto, e, nw);
        wc0 = we_count;
        foreach (fto[i]) send_byte(fto[i]);
        repeat (1000) @(negedge clk);
        chk("tmo_not_early", error, 1'b0);
        chk("tmo_not_early_ready", in_ready, 1'b1);
        wait_result(lat);
        chk("tmo_error", error, e);
        chk("tmo_done", done, 1'b0);
        chk("tmo_hold", cpu_hold, 1'b1);
        chk("tmo_ready", in_ready, 1'b0);
        chk("tmo_words", words_loaded, nw);
        chk("tmo_we_pulses", we_count - wc0, 0);
        $display("frame tmo: stalled, error=%0b after %0d extra cycles", error, lat);
        pulse_start("tmo");
        clear_mem();
        run_frame("reload", f1, 0, lat);
        chk("reload_mem0", mem[0], 32'h00500293);
        chk("reload_mem1", mem[1], 32'h003282B3);
        pulse_start("reload");

        // Backpressure: valid every other cycle
        clear_mem();
        run_frame("bp", f1, 1, lat);
        chk("bp_mem0", mem[0], 32'h00500293);
        chk("bp_mem1", mem[1], 32'h003282B3);
        pulse_start("bp");

        // Asynchronous reset in the middle of the second word
        clear_mem();
        model_frame(f1, e, nw);
        for (int i = 0; i < 7; i++) send_byte(f1[i]);
        #2 rst = 1'b0;
        #1;
        chk("arst_imem_we", imem_we, 1'b0);
        chk("arst_waddr", imem_waddr, 0);
        chk("arst_wdata", imem_wdata, 0);
        chk("arst_hold", cpu_hold, 1'b1);
        chk("arst_done", done, 1'b0);
        chk("arst_words", words_loaded, 0);
        chk("arst_ready", in_ready, 1'b1);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("arst_mem0_kept", mem[0], 32'h00500293);
        chk("arst_mem1_unwritten", mem[1], 32'h0);
        $display("frame arst: reset after 7 bytes, writes seen=%0d", we_count);
        run_frame("after_rst", f1, 0, lat);
        chk("after_rst_mem1", mem[1], 32'h003282B3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
